backend_rst_scheduler: RTL and testbench
========================================

// Module: backend_rst_scheduler
// PURPOSE
//  Sequences reset-code frames onto the per-backend m_rst lines (before ODDR/OBUFDS), one port per active frame.
//  Latches per-port and broadcast requests from the soft-core GPIO and grants them round-robin.
//  Streams the idle code continuously and enforces guard frames between active codes.
//  Sits in the sync top level on sys_clk between GPIO outputs and the backend reset ODDRs.
// PARAMETERS
//  NBACKEND     4        number of backend ports
//  CODE_BITS    4        bits per frame, sent MSB first, one bit per sys_clk
//  CODE_IDLE    4'b1010  idle frame pattern
//  CODE_ACTIVE  4'b1100  reset frame pattern
//  GUARD_FRAMES 2        idle frames forced after each active frame (>=1)
// PORTS
//  sys_clk     in   1         system clock
//  sys_rst_n   in   1         asynchronous active-low reset
//  en          in   1         1 = new active frames may start
//  port_req    in   NBACKEND  per-port request; rising edge latches one request
//  bcast_req   in   1         broadcast request; rising edge latches
//  m_rst       out  NBACKEND  serial code per port, to the ODDR D1/D2 inputs
//  frame_start out  1         high on the cycle carrying bit CODE_BITS-1 of any frame
//  pending     out  NBACKEND  latched, unserved per-port requests
//  bcast_pend  out  1         latched, unserved broadcast
//  busy        out  1         state != S_IDLE
//  done        out  1         one-cycle pulse on last bit of an active frame
//  done_mask   out  NBACKEND  ports served by that frame; valid while done=1, else 0
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): m_rst all = CODE_IDLE[MSB] (1); bit_cnt=0; state S_IDLE.
//   pending=0, bcast_pend=0, req edge regs=0, rr=0; done=0, done_mask=0, busy=0, frame_start=1.
//  Reset mid-frame aborts the frame; lines restart the idle pattern from bit CODE_BITS-1 after release.
//  bit_cnt counts CODE_BITS-1 down to 0 and wraps every cycle; boundary = bit_cnt==0.
//  m_rst[i] = frame_reg[i][bit_cnt]; frame_reg loads at the boundary for the next frame.
//  Edge detect: req_d <= port_req; a rise sets pending[i] on the next cycle.
//   A rise coinciding with the clear of pending[i] leaves it set (new request wins).
//   Same rule applies to bcast_pend.
//  States (evaluated at the boundary only):
//   S_IDLE: if en & bcast_pend -> S_ACTIVE, all ports CODE_ACTIVE; clear bcast_pend and all pending.
//     elif en & |pending -> S_ACTIVE; grant g = first set index from rr upward (wrapping).
//       Port g gets CODE_ACTIVE, others CODE_IDLE; clear pending[g]; rr <= (g+1) mod NBACKEND.
//     else -> stay; all CODE_IDLE.
//   S_ACTIVE: at boundary, done=1 with done_mask; -> S_GUARD, guard_cnt=GUARD_FRAMES-1, all CODE_IDLE.
//   S_GUARD: at boundary, if guard_cnt==0 -> S_IDLE decision applies the same cycle, else guard_cnt-1.
//  Broadcast has priority over per-port requests; rr is unchanged by a broadcast.
//  en=0 never aborts a frame in flight; it only blocks starts. Pending requests are retained.
//  Latency: req rise to first active bit <= CODE_BITS+2 cycles when S_IDLE.
//  Min spacing between active frames = (GUARD_FRAMES+1)*CODE_BITS cycles.
//  All outputs are registered except m_rst, which is a mux of frame_reg by bit_cnt.
// TESTING
//  Idle: release reset, en=1, no requests -> every m_rst line repeats 1,0,1,0; busy=0; done never pulses.
//  Single: port_req[2] rises -> one frame 1,1,0,0 on m_rst[2] only; done=1 with done_mask=4'b0100.
//   Then 2 idle guard frames; pending[2] clears.
//  Round-robin: ports 0,1,3 rise in the same cycle, rr=0 -> service order 0,1,3, each separated by 8 idle cycles.
//   rr ends at 0.
//  Broadcast: bcast plus pending 4'b0011 -> one frame with all four lines 1100.
//   done_mask=4'b1111; pending=0 afterwards; rr unchanged.
//  Gating/collision: en=0 with port_req[1] rising -> no active frame, pending[1]=1.
//   en=1 -> served at the next boundary.
//   A re-rise of port_req[1] on its clear cycle -> served again after the guard frames.
//  Async reset asserted at bit 2 of an active frame -> m_rst=4'b1111 immediately; all status zero.
//   After release, idle pattern only.

Source files
------------

// File: rtl/backend_rst_scheduler.sv
// Serialises idle/reset code frames onto the per-backend m_rst lines and grants
// latched per-port and broadcast requests round-robin, with guard frames after each reset frame.
module backend_rst_scheduler #(
  parameter int                   NBACKEND     = 4,
  parameter int                   CODE_BITS    = 4,
  parameter logic [CODE_BITS-1:0] CODE_IDLE    = 4'b1010,
  parameter logic [CODE_BITS-1:0] CODE_ACTIVE  = 4'b1100,
  parameter int                   GUARD_FRAMES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic [NBACKEND-1:0] port_req,
  input  logic                bcast_req,
  output logic [NBACKEND-1:0] m_rst,
  output logic                frame_start,
  output logic [NBACKEND-1:0] pending,
  output logic                bcast_pend,
  output logic                busy,
  output logic                done,
  output logic [NBACKEND-1:0] done_mask
);

  localparam int BW = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
  localparam int IW = (NBACKEND > 1) ? $clog2(NBACKEND) : 1;
  localparam int GW = (GUARD_FRAMES > 1) ? $clog2(GUARD_FRAMES) : 1;
  localparam logic [BW-1:0] BIT_MSB = BW'(CODE_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GUARD} state_t;

  state_t              state, state_next;
  logic [BW-1:0]       bit_cnt;
  logic [GW-1:0]       guard_cnt, guard_next;
  logic [IW-1:0]       rr, rr_next;
  logic [NBACKEND-1:0] active_mask, mask_next;
  logic [NBACKEND-1:0] req_d, rise, pend_clr;
  logic                bcast_d, bcast_rise, bcast_clr;
  logic                boundary;
  logic                hi_found;
  logic [IW-1:0]       hi_idx, lo_idx, grant_idx;

  assign boundary   = (bit_cnt == '0);
  assign rise       = port_req & ~req_d;
  assign bcast_rise = bcast_req & ~bcast_d;

  // Lowest pending index at or above rr wins; otherwise the lowest pending index overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NBACKEND - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= rr) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
  end

  assign grant_idx = hi_found ? hi_idx : lo_idx;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_next = state;
    guard_next = guard_cnt;
    mask_next  = active_mask;
    rr_next    = rr;
    pend_clr   = '0;
    bcast_clr  = 1'b0;
    if (boundary) begin
      logic decide;
      decide    = 1'b0;
      mask_next = '0;
      case (state)
        S_ACTIVE: begin
          state_next = S_GUARD;
          guard_next = GW'(GUARD_FRAMES - 1);
        end
        S_GUARD: begin
          if (guard_cnt != '0) guard_next = guard_cnt - 1'b1;
          else                 decide     = 1'b1;
        end
        default: decide = 1'b1;
      endcase
      if (decide) begin
        state_next = S_IDLE;
        if (en && bcast_pend) begin
          state_next = S_ACTIVE;
          mask_next  = '1;
          pend_clr   = '1;
          bcast_clr  = 1'b1;
        end else if (en && (|pending)) begin
          state_next           = S_ACTIVE;
          mask_next[grant_idx] = 1'b1;
          pend_clr             = mask_next;
          rr_next = (grant_idx == IW'(NBACKEND - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBACKEND; i++)
      m_rst[i] = active_mask[i] ? CODE_ACTIVE[bit_cnt] : CODE_IDLE[bit_cnt];
  end

  // Reset parks the counter on the MSB so the lines sit at the idle pattern's first bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= BIT_MSB;
      guard_cnt   <= '0;
      rr          <= '0;
      active_mask <= '0;
      req_d       <= '0;
      bcast_d     <= 1'b0;
      pending     <= '0;
      bcast_pend  <= 1'b0;
      frame_start <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_mask   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_next;
      bit_cnt     <= boundary ? BIT_MSB : bit_cnt - 1'b1;
      guard_cnt   <= guard_next;
      rr          <= rr_next;
      active_mask <= mask_next;
      req_d       <= port_req;
      bcast_d     <= bcast_req;
      pending     <= (pending & ~pend_clr) | rise;
      bcast_pend  <= (bcast_pend & ~bcast_clr) | bcast_rise;
      frame_start <= boundary;
      busy        <= (state_next != S_IDLE);
      done        <= (state == S_ACTIVE) && (bit_cnt == BW'(1));
      done_mask   <= ((state == S_ACTIVE) && (bit_cnt == BW'(1))) ? active_mask : '0;
    end
  end

endmodule

// File: tb/tb_backend_rst_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts line codes and done pulses,
// and a negedge monitor compares the DUT against it.
module tb_backend_rst_scheduler;

  localparam int N  = 4;
  localparam int CB = 4;
  localparam int G  = 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] port_req;
  logic         bcast_req;
  logic [N-1:0] m_rst;
  logic         frame_start;
  logic [N-1:0] pending;
  logic         bcast_pend;
  logic         busy;
  logic         done;
  logic [N-1:0] done_mask;

  backend_rst_scheduler dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .en          (en),
    .port_req    (port_req),
    .bcast_req   (bcast_req),
    .m_rst       (m_rst),
    .frame_start (frame_start),
    .pending     (pending),
    .bcast_pend  (bcast_pend),
    .busy        (busy),
    .done        (done),
    .done_mask   (done_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [CB-1:0] code_act  = 4'b1100;
  logic [CB-1:0] code_idle = 4'b1010;

  // Reference model state, advanced once per clock, in frames of CB cycles.
  int           cyc;
  int           guard_left;
  int           m_rr;
  logic [N-1:0] m_pend, m_prev, cur_mask;
  logic         m_bpend, m_bprev, cur_guard;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Model: at the end of each frame pick the content of the next one, then latch request edges.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0; guard_left = 0; m_rr = 0;
        m_pend = '0; m_prev = '0; cur_mask = '0;
        m_bpend = 1'b0; m_bprev = 1'b0; cur_guard = 1'b0;
        exp_q.delete();
      end else begin
        logic [N-1:0] clr, next_mask;
        logic         bclr, next_guard;
        clr = '0; bclr = 1'b0; next_mask = '0; next_guard = 1'b0;
        if (cyc % CB == CB - 1) begin
          if (cur_mask != '0) begin
            guard_left = G;
            next_guard = 1'b1;
          end else begin
            if (guard_left > 0) guard_left--;
            if (guard_left > 0) next_guard = 1'b1;
            else if (en && m_bpend) begin
              next_mask = '1; clr = '1; bclr = 1'b1;
            end else if (en && m_pend != '0) begin
              int g;
              g = -1;
              for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
              next_mask[g] = 1'b1;
              clr = next_mask;
              m_rr = (g + 1) % N;
            end
          end
          if (next_mask != '0) exp_q.push_back('{mask: next_mask, cyc: cyc + CB});
          cur_mask  = next_mask;
          cur_guard = next_guard;
        end
        m_pend  = (m_pend & ~clr) | (port_req & ~m_prev);
        m_prev  = port_req;
        m_bpend = (m_bpend & ~bclr) | (bcast_req & ~m_bprev);
        m_bprev = bcast_req;
        cyc++;
      end
    end
  end

  // Monitor: compare lines and status every cycle; done pulses are popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_m_rst", 32'(m_rst), 32'hf);
        check("rst_frame_start", 32'(frame_start), 32'd1);
        check("rst_status", {27'd0, busy, done, bcast_pend, 2'd0}, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_done_mask", 32'(done_mask), 32'd0);
      end else begin
        logic [N-1:0] exp_m;
        logic         exp_done;
        int           bitpos;
        bitpos = CB - 1 - (cyc % CB);
        for (int i = 0; i < N; i++)
          exp_m[i] = cur_mask[i] ? code_act[bitpos] : code_idle[bitpos];
        check("m_rst", 32'(m_rst), 32'(exp_m));
        check("frame_start", 32'(frame_start), 32'(cyc % CB == 0));
        check("busy", 32'(busy), 32'((cur_mask != '0) || cur_guard));
        check("pending", 32'(pending), 32'(m_pend));
        check("bcast_pend", 32'(bcast_pend), 32'(m_bpend));
        exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
          check("done_mask", 32'(done_mask), 32'(exp_q[0].mask));
          void'(exp_q.pop_front());
        end else begin
          check("done_mask_idle", 32'(done_mask), 32'd0);
        end
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic found;
    rst_n = 1'b1; en = 1'b0; port_req = '0; bcast_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();

    // Idle stream only.
    @(negedge clk) en = 1'b1;
    repeat (24) @(negedge clk);

    // Single request on port 2.
    port_req[2] = 1'b1;
    @(negedge clk) port_req[2] = 1'b0;
    repeat (40) @(negedge clk);

    // Ports 0, 1 and 3 together: round-robin order.
    port_req = 4'b1011;
    @(negedge clk) port_req = '0;
    repeat (50) @(negedge clk);

    // Broadcast on top of pending ports 0 and 1.
    en = 1'b0;
    port_req = 4'b0011;
    @(negedge clk) port_req = '0; bcast_req = 1'b1;
    @(negedge clk) bcast_req = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);

    // Gating: requests are held while en=0, served once enabled.
    en = 1'b0;
    port_req[1] = 1'b1;
    @(negedge clk) port_req[1] = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);

    // Collision: re-rise of port_req[1] on the cycle its pending bit clears.
    en = 1'b0;
    port_req[1] = 1'b1;
    @(negedge clk) port_req[1] = 1'b0;
    repeat (10) @(negedge clk);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (cyc % CB == CB - 1 && cur_mask == '0 && !cur_guard) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_boundary", 32'(found), 32'd1);
    en = 1'b1; port_req[1] = 1'b1;
    @(negedge clk) port_req[1] = 1'b0;
    repeat (40) @(negedge clk);

    // Randomised requests, broadcasts and enable.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 19) == 0) port_req[i] = ~port_req[i];
      if ($urandom_range(0, 59) == 0) bcast_req = ~bcast_req;
    end
    @(negedge clk) en = 1'b1; port_req = '0; bcast_req = 1'b0;
    repeat (100) @(negedge clk);

    // Asynchronous reset while an active frame is on bit 2.
    port_req[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (cur_mask != '0 && (cyc % CB) == 1) found = 1'b1;
    end
    check("reach_bit2", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_m_rst", 32'(m_rst), 32'hf);
    check("midrst_status", {27'd0, busy, done, bcast_pend, 2'd0}, 32'd0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_done_mask", 32'(done_mask), 32'd0);
    @(negedge clk) port_req = '0;
    repeat (3) @(negedge clk);
    release_reset();
    repeat (24) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
